// File: rtl/traffic_sink.sv
// Packet sink for a NoC endpoint: reassembles flit streams, checks routing and
// collects latency/throughput statistics plus an idle ("quiet") indication.
module traffic_sink #(
    parameter int unsigned DATA_BITS    = 32,
    parameter int unsigned ADDR_BITS    = 4,
    parameter int unsigned MY_ADDR      = 0,
    parameter int unsigned TS_BITS      = 16,
    parameter int unsigned CNT_BITS     = 16,
    parameter int unsigned QUIET_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         in_valid,
    input  logic [DATA_BITS-1:0]         in_data,
    output logic                         in_ready,
    output logic                         pkt_done,
    output logic [TS_BITS-1:0]           last_latency,
    output logic [TS_BITS-1:0]           lat_max,
    output logic [CNT_BITS+TS_BITS-1:0]  lat_sum,
    output logic [CNT_BITS-1:0]          pkt_count,
    output logic [CNT_BITS-1:0]          flit_count,
    output logic [CNT_BITS-1:0]          err_count,
    output logic                         quiet
);
    localparam int unsigned SUM_BITS  = CNT_BITS + TS_BITS;
    localparam int unsigned SUM_EXT   = SUM_BITS + 1;
    localparam int unsigned IDLE_BITS = $clog2(QUIET_CYCLES + 1);

    localparam logic [IDLE_BITS-1:0] IDLE_MAX   = IDLE_BITS'(QUIET_CYCLES);
    localparam logic [ADDR_BITS-1:0] LOCAL_ADDR = ADDR_BITS'(MY_ADDR);

    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b01;
    localparam logic [1:0] TYPE_HEAD   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BODY = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [TS_BITS-1:0]   now_q, now_d;
    logic [TS_BITS-1:0]   ts_q, ts_d;
    logic [ADDR_BITS-1:0] dst_q, dst_d;
    logic [IDLE_BITS-1:0] idle_q, idle_d;
    logic                 pkt_done_q, pkt_done_d;
    logic                 quiet_q, quiet_d;
    logic [TS_BITS-1:0]   last_lat_q, last_lat_d;
    logic [TS_BITS-1:0]   lat_max_q, lat_max_d;
    logic [SUM_BITS-1:0]  lat_sum_q, lat_sum_d;
    logic [CNT_BITS-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_BITS-1:0]  flit_cnt_q, flit_cnt_d;
    logic [CNT_BITS-1:0]  err_cnt_q, err_cnt_d;

    logic                 accept;
    logic [1:0]           flit_type;
    logic [TS_BITS-1:0]   flit_ts;
    logic [ADDR_BITS-1:0] flit_dst;
    logic                 complete;
    logic                 err_inc;
    logic                 good;
    logic [TS_BITS-1:0]   cmp_ts;
    logic [ADDR_BITS-1:0] cmp_dst;
    logic [TS_BITS-1:0]   latency;
    logic [SUM_BITS:0]    sum_ext;

    // Reserved payload bits between the timestamp and type fields are ignored.
    logic unused_data;
    assign unused_data = ^in_data;

    assign in_ready  = enable & ~reset;
    assign accept    = in_valid & in_ready;
    assign flit_type = in_data[DATA_BITS-1 -: 2];
    assign flit_ts   = in_data[ADDR_BITS +: TS_BITS];
    assign flit_dst  = in_data[ADDR_BITS-1:0];

    // Next-state, packet reassembly and statistics update.
    always_comb begin
        state_d    = state_q;
        now_d      = now_q + 1'b1;
        ts_d       = ts_q;
        dst_d      = dst_q;
        idle_d     = idle_q;
        pkt_done_d = 1'b0;
        last_lat_d = last_lat_q;
        lat_max_d  = lat_max_q;
        lat_sum_d  = lat_sum_q;
        pkt_cnt_d  = pkt_cnt_q;
        flit_cnt_d = flit_cnt_q;
        err_cnt_d  = err_cnt_q;
        complete   = 1'b0;
        err_inc    = 1'b0;
        cmp_ts     = ts_q;
        cmp_dst    = dst_q;

        if (accept) begin
            if (state_q == ST_BODY && flit_type == TYPE_TAIL) begin
                complete = 1'b1;
                state_d  = ST_IDLE;
            end else if (state_q == ST_BODY && flit_type == TYPE_BODY) begin
                state_d = ST_BODY;
            end else begin
                // A HEAD/SINGLE arriving mid-packet aborts it, then starts afresh.
                if (state_q == ST_BODY) begin
                    err_inc = 1'b1;
                end
                case (flit_type)
                    TYPE_HEAD: begin
                        ts_d    = flit_ts;
                        dst_d   = flit_dst;
                        state_d = ST_BODY;
                    end
                    TYPE_SINGLE: begin
                        complete = 1'b1;
                        cmp_ts   = flit_ts;
                        cmp_dst  = flit_dst;
                        state_d  = ST_IDLE;
                    end
                    default: begin
                        err_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end

        latency = now_q - cmp_ts;
        sum_ext = {1'b0, lat_sum_q} + SUM_EXT'(latency);
        good    = complete && (cmp_dst == LOCAL_ADDR);
        if (complete && !good) begin
            err_inc = 1'b1;
        end

        if (good) begin
            pkt_done_d = 1'b1;
            last_lat_d = latency;
            lat_sum_d  = sum_ext[SUM_BITS] ? '1 : sum_ext[SUM_BITS-1:0];
            if (latency > lat_max_q) begin
                lat_max_d = latency;
            end
            if (pkt_cnt_q != '1) begin
                pkt_cnt_d = pkt_cnt_q + 1'b1;
            end
        end

        if (accept && flit_cnt_q != '1) begin
            flit_cnt_d = flit_cnt_q + 1'b1;
        end
        if (err_inc && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end

        if (accept) begin
            idle_d = '0;
        end else if (idle_q != IDLE_MAX) begin
            idle_d = idle_q + 1'b1;
        end
        quiet_d = (idle_d == IDLE_MAX) && (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            now_q      <= '0;
            ts_q       <= '0;
            dst_q      <= '0;
            idle_q     <= '0;
            pkt_done_q <= 1'b0;
            quiet_q    <= 1'b0;
            last_lat_q <= '0;
            lat_max_q  <= '0;
            lat_sum_q  <= '0;
            pkt_cnt_q  <= '0;
            flit_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            now_q      <= now_d;
            ts_q       <= ts_d;
            dst_q      <= dst_d;
            idle_q     <= idle_d;
            pkt_done_q <= pkt_done_d;
            quiet_q    <= quiet_d;
            last_lat_q <= last_lat_d;
            lat_max_q  <= lat_max_d;
            lat_sum_q  <= lat_sum_d;
            pkt_cnt_q  <= pkt_cnt_d;
            flit_cnt_q <= flit_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign pkt_done     = pkt_done_q;
    assign quiet        = quiet_q;
    assign last_latency = last_lat_q;
    assign lat_max      = lat_max_q;
    assign lat_sum      = lat_sum_q;
    assign pkt_count    = pkt_cnt_q;
    assign flit_count   = flit_cnt_q;
    assign err_count    = err_cnt_q;
endmodule

// File: tb/tb_traffic_sink.sv
// Directed bench for traffic_sink: expected latencies are queued when a good
// packet completes on the input side and popped when pkt_done pulses.
module tb_traffic_sink;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;
    localparam logic [3:0] MY       = 4'd0;
    localparam logic [3:0] OTHER    = 4'd1;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        pkt_done;
    logic [15:0] last_latency;
    logic [15:0] lat_max;
    logic [31:0] lat_sum;
    logic [15:0] pkt_count;
    logic [15:0] flit_count;
    logic [15:0] err_count;
    logic        quiet;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] tb_now;
    logic [15:0] ts_tmp;

    traffic_sink dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .pkt_done    (pkt_done),
        .last_latency(last_latency),
        .lat_max     (lat_max),
        .lat_sum     (lat_sum),
        .pkt_count   (pkt_count),
        .flit_count  (flit_count),
        .err_count   (err_count),
        .quiet       (quiet)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference copy of the free-running cycle counter.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_now <= 16'd0;
        else       tb_now <= tb_now + 16'd1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"},   64'(in_ready),     64'd0);
        check({tag, "_pkt_done"},   64'(pkt_done),     64'd0);
        check({tag, "_last_lat"},   64'(last_latency), 64'd0);
        check({tag, "_lat_max"},    64'(lat_max),      64'd0);
        check({tag, "_lat_sum"},    64'(lat_sum),      64'd0);
        check({tag, "_pkt_count"},  64'(pkt_count),    64'd0);
        check({tag, "_flit_count"}, 64'(flit_count),   64'd0);
        check({tag, "_err_count"},  64'(err_count),    64'd0);
        check({tag, "_quiet"},      64'(quiet),        64'd0);
    endtask

    task automatic check_stats(input string tag, input logic [15:0] pk, input logic [15:0] fl,
                               input logic [15:0] er);
        check({tag, "_pkt_count"},  64'(pkt_count),  64'(pk));
        check({tag, "_flit_count"}, 64'(flit_count), 64'(fl));
        check({tag, "_err_count"},  64'(err_count),  64'(er));
    endtask

    function automatic logic [31:0] mk(input logic [1:0] t, input logic [15:0] ts, input logic [3:0] d);
        return {t, 10'd0, ts, d};
    endfunction

    // Called at a negedge; the flit is accepted at the following posedge.
    task automatic flit(input logic [1:0] t, input logic [15:0] ts, input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = mk(t, ts, d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check_zero(tag);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_now(input logic [15:0] target);
        int n = 0;
        while (tb_now != target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n == 1000) check("wait_now_timeout", 64'(tb_now), 64'(target));
    endtask

    // Scoreboard consumer: every pkt_done pulse must match a queued latency.
    always @(negedge clk) begin
        if (!reset && pkt_done === 1'b1) begin
            if (exp_q.size() == 0) check("pkt_done_spurious", 64'(pkt_done), 64'd0);
            else                   check("pkt_latency", 64'(last_latency), 64'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        in_valid = 1'b0;
        in_data  = 32'd0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        #1;
        check_zero("init");
        @(negedge clk);
        reset = 1'b0;

        // SINGLE ts=5 accepted at now=12
        wait_now(16'd12);
        exp_q.push_back(16'd7);
        flit(T_SINGLE, 16'd5, MY);
        check("s1_pkt_done", 64'(pkt_done), 64'd1);
        check("s1_lat_max", 64'(lat_max), 64'd7);
        check("s1_lat_sum", 64'(lat_sum), 64'd7);
        check_stats("s1", 16'd1, 16'd1, 16'd0);
        @(negedge clk);
        check("s1_pulse_end", 64'(pkt_done), 64'd0);

        // HEAD/3xBODY/TAIL at now=10..14, then a smaller-latency SINGLE
        do_reset("s2_rst");
        wait_now(16'd10);
        flit(T_HEAD, 16'd0, MY);
        for (int i = 0; i < 3; i++) flit(T_BODY, 16'd0, MY);
        exp_q.push_back(16'd14);
        flit(T_TAIL, 16'd0, MY);
        check("s2_lat_max", 64'(lat_max), 64'd14);
        check_stats("s2", 16'd1, 16'd5, 16'd0);
        ts_tmp = tb_now - 16'd3;
        exp_q.push_back(16'd3);
        flit(T_SINGLE, ts_tmp, MY);
        check("s2_lat_max_hold", 64'(lat_max), 64'd14);
        check("s2_lat_sum", 64'(lat_sum), 64'd17);
        check_stats("s2b", 16'd2, 16'd6, 16'd0);

        // Timestamp wrap: ts=0xFFFE completed at now=3
        do_reset("s3_rst");
        wait_now(16'd3);
        exp_q.push_back(16'd5);
        flit(T_SINGLE, 16'hFFFE, MY);
        check("s3_lat_max", 64'(lat_max), 64'd5);
        check("s3_lat_sum", 64'(lat_sum), 64'd5);

        // Error paths
        do_reset("s4_rst");
        flit(T_TAIL, 16'd0, MY);
        check_stats("s4_tail_idle", 16'd0, 16'd1, 16'd1);
        flit(T_HEAD, 16'd1, MY);
        flit(T_HEAD, 16'd2, MY);
        check_stats("s4_abort", 16'd0, 16'd3, 16'd2);
        ts_tmp = tb_now - 16'd2;
        exp_q.push_back(ts_tmp);
        flit(T_TAIL, 16'd0, MY);
        check_stats("s4_tail", 16'd1, 16'd4, 16'd2);
        flit(T_SINGLE, 16'd0, OTHER);
        check_stats("s4_misroute", 16'd1, 16'd5, 16'd3);
        flit(T_HEAD, 16'd0, MY);
        flit(T_SINGLE, 16'd0, OTHER);
        check_stats("s4_one_err", 16'd1, 16'd7, 16'd4);
        flit(T_HEAD, 16'd0, 4'd5);
        flit(T_TAIL, 16'd0, MY);
        check_stats("s4_latched_dst", 16'd1, 16'd9, 16'd5);

        // Enable low, quiet timing, quiet gated by packet in progress
        do_reset("s5_rst");
        ts_tmp = tb_now;
        exp_q.push_back(16'd0);
        flit(T_SINGLE, ts_tmp, MY);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = mk(T_HEAD, 16'd0, MY);
        for (int i = 1; i <= 64; i++) begin
            @(negedge clk);
            if (i <= 10) check("s5_in_ready_low", 64'(in_ready), 64'd0);
            if (i == 63) check("s5_quiet_63", 64'(quiet), 64'd0);
            if (i == 64) check("s5_quiet_64", 64'(quiet), 64'd1);
        end
        check_stats("s5_hold", 16'd1, 16'd1, 16'd0);
        enable = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("s5_quiet_clear", 64'(quiet), 64'd0);
        check("s5_flit_count", 64'(flit_count), 64'd2);
        repeat (70) @(negedge clk);
        check("s5_quiet_in_body", 64'(quiet), 64'd0);
        exp_q.push_back(tb_now);
        flit(T_TAIL, 16'd0, MY);
        check_stats("s5_done", 16'd2, 16'd3, 16'd0);

        // Asynchronous reset between HEAD and TAIL
        do_reset("s6_rst");
        flit(T_HEAD, 16'd0, MY);
        check("s6_flit_count", 64'(flit_count), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_zero("s6_async");
        @(negedge clk);
        reset = 1'b0;
        flit(T_TAIL, 16'd0, MY);
        check_stats("s6_tail", 16'd0, 16'd1, 16'd1);

        repeat (2) @(negedge clk);
        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/traffic_sink.md
TRAFFIC_SINK -- requirements
Module: traffic_sink

Interface
REQ-001 SHALL have parameter DATA_BITS, default 32, flit width.
REQ-002 SHALL have parameter ADDR_BITS, default 4, node address width.
REQ-003 SHALL have parameter MY_ADDR, default 0, this node's address.
REQ-004 SHALL have parameter TS_BITS, default 16, timestamp and latency width.
REQ-005 SHALL have parameter CNT_BITS, default 16, statistics counter width.
REQ-006 SHALL have parameter QUIET_CYCLES, default 64, idle cycles before quiet asserts.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port reset, input, 1, reset; asynchronous, active-high.
REQ-009 SHALL have port enable, input, 1, sink accepts flits when high.
REQ-010 SHALL have port in_valid, input, 1, flit present.
REQ-011 SHALL have port in_data, input, DATA_BITS, flit: [DATA_BITS-1:DATA_BITS-2] type, [TS_BITS+ADDR_BITS-1:ADDR_BITS] timestamp, [ADDR_BITS-1:0] destination.
REQ-012 SHALL have port in_ready, output, 1, flit accepted this cycle when in_valid & in_ready.
REQ-013 SHALL have port pkt_done, output, 1, one-cycle pulse on packet completion.
REQ-014 SHALL have port last_latency, output, TS_BITS, latency of most recent packet.
REQ-015 SHALL have port lat_max, output, TS_BITS, maximum latency seen.
REQ-016 SHALL have port lat_sum, output, CNT_BITS+TS_BITS, saturating latency sum.
REQ-017 SHALL have port pkt_count, output, CNT_BITS, good packets received.
REQ-018 SHALL have port flit_count, output, CNT_BITS, flits accepted.
REQ-019 SHALL have port err_count, output, CNT_BITS, misrouted or malformed packets.
REQ-020 SHALL have port quiet, output, 1, no traffic for QUIET_CYCLES cycles and no packet in progress.

Function
REQ-021 SHALL run a free-running TS_BITS cycle counter `now`, incrementing every clock and wrapping modulo 2^TS_BITS.
REQ-022 SHALL drive in_ready = enable & ~reset, combinationally; a flit is accepted only on in_valid & in_ready.
REQ-023 SHALL decode type: 2'b10 HEAD, 2'b00 BODY, 2'b01 TAIL, 2'b11 SINGLE (head and tail).
REQ-024 SHALL implement FSM states IDLE and BODY; reset state IDLE.
REQ-025 SHALL, in IDLE, on accepted HEAD: latch timestamp and destination, go to BODY.
REQ-026 SHALL, in IDLE, on accepted SINGLE: complete packet in the same cycle, stay in IDLE.
REQ-027 SHALL, in IDLE, on accepted BODY or TAIL: increment err_count once, stay in IDLE.
REQ-028 SHALL, in BODY, on accepted BODY: stay in BODY, no statistics change besides flit_count.
REQ-029 SHALL, in BODY, on accepted TAIL: complete packet, go to IDLE.
REQ-030 SHALL, in BODY, on accepted HEAD or SINGLE: increment err_count for the aborted packet, then treat the flit as in IDLE (a new HEAD latches and stays in BODY; a SINGLE completes and goes to IDLE).
REQ-031 SHALL compute latency at completion as (now - latched timestamp) modulo 2^TS_BITS.
REQ-032 SHALL, at completion with destination == MY_ADDR: pulse pkt_done the next cycle, register last_latency, add latency to lat_sum (saturate at all-ones), update lat_max if greater, increment pkt_count.
REQ-033 SHALL, at completion with destination != MY_ADDR: increment err_count only; no pkt_done, no latency update.
REQ-034 SHALL increment flit_count on every accepted flit, including erroneous ones.
REQ-035 SHALL saturate pkt_count, flit_count and err_count at all-ones (no wrap).
REQ-036 SHALL increment err_count by at most 1 per cycle.
REQ-037 SHALL count idle cycles since the last accepted flit, saturating at QUIET_CYCLES, and clear the count on each accepted flit.
REQ-038 SHALL assert quiet, registered, when the idle count == QUIET_CYCLES and the FSM is in IDLE.
REQ-039 SHALL hold the FSM state and all statistics while enable is low; the now and idle counters keep running.

Reset
REQ-040 SHALL, on reset assertion (asynchronous, mid-packet included), force FSM to IDLE and now, the idle count, pkt_done, quiet, last_latency, lat_max, lat_sum and all counts to 0.
REQ-041 SHALL discard any partially received packet at reset without counting an error.

Verification
REQ-042 SHALL show: SINGLE dest=MY_ADDR ts=5 accepted at now=12 -> pkt_done pulse next cycle, last_latency=7, pkt_count=1, flit_count=1.
REQ-043 SHALL show: HEAD ts=0, 3 BODY, TAIL, dest=MY_ADDR, accepted at now=10..14 -> last_latency=14, flit_count=5, pkt_count=1.
REQ-044 SHALL show: timestamp 0xFFFE completed at now=0x0003 -> latency=5 (wrap).
REQ-045 SHALL show: TAIL in IDLE, then HEAD-HEAD-TAIL, then SINGLE dest=MY_ADDR+1 -> err_count=3, pkt_count=1.
REQ-046 SHALL show: in_valid high with enable low for 10 cycles -> in_ready=0, flit_count unchanged; quiet=1 after 64 idle cycles; a new flit -> quiet=0 next cycle.
REQ-047 SHALL show: reset asserted between HEAD and TAIL -> all outputs 0; a following TAIL -> err_count=1.
